mem_bus_arbiter: RTL

//  Shares one native memory port (valid/ready, addr/wdata/wstrb, rdata) among
//  NUM_MASTERS requesters: CPU core, loader/DMA, debug. Sits between the

---
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the requester-side and memory-side signals of the shared native
//   memory port so the arbiter, its requesters and the slave see one bus.
//
//   Requester side (flattened, master i occupies slice i):
//     m_valid  [N]      request, held until the matching m_ready
//     m_addr   [N*32]   address,    master i at [32*i +: 32]
//     m_wdata  [N*32]   write data, master i at [32*i +: 32]
//     m_wstrb  [N*4]    byte strobes, master i at [4*i +: 4]; 0 = read
//     m_ready  [N]      one-hot completion pulse to the granted master
//     m_rdata  [32]     read data broadcast, valid only with m_ready
//   Memory side:
//     mem_valid/mem_addr/mem_wdata/mem_wstrb   request to the slave
//     mem_ready/mem_rdata                      slave completion and data
//
//   Modports:
//     arbiter  the mem_bus_arbiter itself
//     master   the requester population (drives m_*)
//     slave    the memory/UART slave (drives mem_ready/mem_rdata)
// ----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    m_valid;
    logic [NUM_MASTERS*32-1:0] m_addr;
    logic [NUM_MASTERS*32-1:0] m_wdata;
    logic [NUM_MASTERS*4-1:0]  m_wstrb;
    logic [NUM_MASTERS-1:0]    m_ready;
    logic [31:0]               m_rdata;

    logic                      mem_valid;
    logic [31:0]               mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_wstrb;
    logic                      mem_ready;
    logic [31:0]               mem_rdata;

    modport arbiter (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one native valid/ready memory port among NUM_MASTERS requesters
//   (CPU core, loader/DMA, debug). Round-robin arbitration, exactly one
//   transaction in flight, and a per-transaction watchdog that completes a
//   hung transaction with an error response.
//
//   Parameters:
//     NUM_MASTERS     number of requesters (2..8)
//     TIMEOUT_CYCLES  BUSY cycles without mem_ready before abort; 0 disables
//     ERR_RDATA       read data returned to the master on a watchdog abort
//
//   Ports:
//     clk          clock, all logic on posedge
//     reset        asynchronous, active-low reset
//     bus          mem_bus_arbiter_if.arbiter (requester + memory side)
//     grant_id     current / most recently granted master
//     busy         a transaction is in flight
//     timeout_err  one-cycle pulse on a watchdog abort
//
//   Timing: IDLE picks a winner and registers it (1 cycle arbitration
//   latency); BUSY forwards the winner's request combinationally and returns
//   completion in the same cycle as mem_ready. Every grant is followed by at
//   least one IDLE cycle.
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           reset,
    mem_bus_arbiter_if.arbiter             bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int GRANT_W = $clog2(NUM_MASTERS);
    // Sized so the counter can hold TIMEOUT_CYCLES; kept at 1 bit when the
    // watchdog is disabled so the declaration stays legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [NUM_MASTERS-1:0] ONE_HOT_0 = NUM_MASTERS'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [GRANT_W-1:0] rr_ptr;
    logic [CNT_W-1:0]   tmo_cnt;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    // Scanning from the far end down lets the nearest candidate win by
    // being written last.
    // ------------------------------------------------------------------
    logic [GRANT_W-1:0] next_grant;
    logic [GRANT_W-1:0] cand;
    logic               any_req;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the block leaves it unassigned and no latch appears.
        next_grant = '0;
        cand       = '0;
        any_req    = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = GRANT_W'((int'(rr_ptr) + k) % NUM_MASTERS);
            if (bus.m_valid[cand]) begin
                next_grant = cand;
                any_req    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted master's request, selected combinationally.
    // ------------------------------------------------------------------
    logic        g_valid;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;
    logic        tmo_hit;
    logic [GRANT_W-1:0] ptr_after;

    assign g_valid = bus.m_valid[grant_id];
    assign g_addr  = bus.m_addr [32 * int'(grant_id) +: 32];
    assign g_wdata = bus.m_wdata[32 * int'(grant_id) +: 32];
    assign g_wstrb = bus.m_wstrb[4 * int'(grant_id) +: 4];

    // The watchdog fires on the TIMEOUT_CYCLES-th BUSY cycle (counter starts
    // at 0 on the first one). A coincident mem_ready takes priority below.
    assign tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt == CNT_LAST);

    assign ptr_after = (grant_id == GRANT_W'(NUM_MASTERS - 1)) ? '0
                                                               : grant_id + GRANT_W'(1);

    assign busy = (state == ST_BUSY);

    // ------------------------------------------------------------------
    // Bus outputs. Completion and error responses are same-cycle so the
    // master sees m_ready together with the slave's mem_ready.
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.m_ready   = '0;
        bus.m_rdata   = '0;
        timeout_err   = 1'b0;
        if (state == ST_BUSY) begin
            bus.mem_addr  = g_addr;
            bus.mem_wdata = g_wdata;
            bus.mem_wstrb = g_wstrb;
            if (!g_valid) begin
                // Granted master withdrew: drop the request, no response.
                bus.mem_valid = 1'b0;
            end else if (bus.mem_ready) begin
                bus.mem_valid = 1'b1;
                bus.m_ready   = ONE_HOT_0 << grant_id;
                bus.m_rdata   = bus.mem_rdata;
            end else if (tmo_hit) begin
                bus.mem_valid = 1'b0;
                bus.m_ready   = ONE_HOT_0 << grant_id;
                bus.m_rdata   = ERR_RDATA;
                timeout_err   = 1'b1;
            end else begin
                bus.mem_valid = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM, round-robin pointer, grant register and watchdog counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            tmo_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates
            // from the values present before this edge, independent of order.
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (any_req) begin
                        grant_id <= next_grant;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!g_valid) begin
                        // Abort keeps rr_ptr so the same priority order resumes.
                        state   <= ST_IDLE;
                        tmo_cnt <= '0;
                    end else if (bus.mem_ready || tmo_hit) begin
                        state   <= ST_IDLE;
                        rr_ptr  <= ptr_after;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != CNT_SAT) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
